perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised performance-statistics unit for the next-generation (pipelined) MIPS CPU. It replaces the fixed four-counter statistics block. It counts retired J/R/I-type instructions and total cycles, plus `N_EXT` external event channels such as stalls, flushes, memory reads and memory writes. It adds halt freeze, synchronous clear, an atomic snapshot into shadow registers read through a select port, and sticky overflow flags. It sits beside the control unit at CPU top level and drives the seven-segment/statistics outputs.

## Interface
Parameters:
- `CNT_W`, 32: width of every counter.
- `N_EXT`, 4: number of external event channels (1..12).
- `SEL_W`, 4: width of `rd_sel`; must satisfy 2^SEL_W ≥ 4+N_EXT.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode of the instruction retiring this cycle.
- `retire`  in  1  high when a real instruction (not a bubble) retires this cycle.
- `halt`  in  1  high freezes all counting.
- `ev`  in  N_EXT  per-channel event pulses; each bit high counts one event that cycle.
- `clr`  in  1  synchronous clear of live counters and overflow flags.
- `snap`  in  1  copy all live counters into shadow registers.
- `rd_sel`  in  SEL_W  shadow register select.
- `rd_data`  out  CNT_W  selected shadow value, combinational.
- `statJ`, `statR`, `statI`, `statTC`  out  CNT_W each  live counters for channels 0–3.
- `ovf`  out  4+N_EXT  sticky per-channel overflow flags.
- `snap_valid`  out  1  high once at least one snapshot has been taken since reset.

## Operation
- Channel map:
  - 0 = J
  - 1 = R
  - 2 = I
  - 3 = TC (total cycles)
  - 4+k = `ev[k]`
- Classification applies only when `retire`=1:
  - `op`=6'h00 → R.
  - `op`=6'h02 or 6'h03 → J.
  - Any other opcode → I.
  - Exactly one of channels 0–2 increments per retire.
- TC increments every cycle in which `halt`=0, whether or not `retire` is asserted.
- `halt`=1 blocks all increments, including J/R/I, TC and ext. `clr` and `snap` are still honoured while halted.
- Increment amount is 1 per channel per cycle.
- Overflow: an increment while the counter equals 2^CNT_W−1 sets that channel's `ovf` bit. The bit stays set until `clr` or reset.
- `snap`: every shadow register is loaded with the live counter value present before this edge's increment. `snap_valid` is set on that edge.
- `clr`: all live counters and `ovf` go to 0 on that edge. Clear wins over any same-cycle increment. Shadows and `snap_valid` are unaffected.
- `clr`+`snap` in the same cycle: shadows capture the pre-clear values; live counters become 0.
- `rd_data` = shadow[`rd_sel`]. It is 0 when `rd_sel` ≥ 4+N_EXT.

## Timing
- Reset (`reset`=0, asynchronous): all live counters, shadows, `ovf` and `snap_valid` go to 0. Hence `rd_data` = 0 and all `stat*` = 0.
- Counting latency: an event sampled at edge n appears on the live output after edge n. There is no further pipelining.
- Snapshot latency: shadow values are visible on `rd_data` the cycle after the `snap` edge.
- `rd_sel` → `rd_data` is purely combinational, with zero cycles of latency.
- Reset asserted mid-count discards all state immediately. Counting resumes on the first rising edge after `reset` returns high.
- Single clock domain. `ev`, `op`, `retire`, `halt`, `clr` and `snap` must be synchronous to `clk`.

## Configuration
- `PERF_SATURATE_EN` defined: a counter at 2^CNT_W−1 holds at all-ones on further increments. `ovf` is still set.
- `PERF_SATURATE_EN` undefined: counters wrap modulo 2^CNT_W, so all-ones + 1 gives 0. `ovf` is set on the wrapping increment.

## Test plan
- Reset then retire sequence with `op` = 00, 02, 23, 03, 2B (retire=1 each), `halt`=0, over 5 cycles → `statR`=1, `statJ`=2, `statI`=2, `statTC`=5.
- `retire`=0 for 3 cycles with `op`=00 → J/R/I unchanged; `statTC` advances by 3.
- `halt`=1 for 4 cycles with `retire`=1 and `ev`=all-ones → no counter changes. `snap` during the halt → shadows equal the frozen values.
- Accumulate TC=7, assert `clr`+`snap` together, then `rd_sel`=3 → `rd_data`=7, `statTC`=0 after the edge, `snap_valid`=1, `ovf`=0.
- `CNT_W`=4, drive `ev[0]` for 17 cycles → without the macro, channel 4 reads 1 and `ovf[4]`=1; with `PERF_SATURATE_EN`, it reads 15 and `ovf[4]`=1.
- Assert `reset` low mid-count after a snapshot → all outputs 0 asynchronously, without waiting for a clock edge. `rd_sel`=9 with `N_EXT`=4 → `rd_data`=0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Purpose: per-instruction-class, cycle and external-event performance counters with snapshot shadows.
// Latency: live counters update one edge after the event is sampled; rd_data is combinational from rd_sel.
// Backpressure: none; events are counted every unhalted cycle and never stalled.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   op, retire        - opcode and valid flag of the retiring instruction (J/R/I classification)
//   halt              - freezes every increment; clr and snap still act
//   ev                - N_EXT external event pulses, channel 4+k
//   clr, snap         - synchronous clear of live counters/ovf; copy live counters into shadows
//   rd_sel, rd_data   - shadow register read port (0 when rd_sel is past the last channel)
//   statJ/R/I/TC      - live counters of channels 0..3
//   ovf, snap_valid   - sticky per-channel overflow flags; a snapshot has been taken since reset
//
// Build option: define PERF_SATURATE_EN to make counters hold at all-ones instead of wrapping.
module perf_counter_bank #(
  parameter int CNT_W = 32,
  parameter int N_EXT = 4,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               retire,
  input  logic               halt,
  input  logic [N_EXT-1:0]   ev,
  input  logic               clr,
  input  logic               snap,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   statJ,
  output logic [CNT_W-1:0]   statR,
  output logic [CNT_W-1:0]   statI,
  output logic [CNT_W-1:0]   statTC,
  output logic [4+N_EXT-1:0] ovf,
  output logic               snap_valid
);

  localparam int NCH = 4 + N_EXT;

  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] shad_q [NCH];
  logic [NCH-1:0]   ovf_q;
  logic [NCH-1:0]   ovf_d;
  logic             snap_valid_q;
  logic [NCH-1:0]   inc;

  // Per-channel increment request; halt masks everything, TC counts every unhalted cycle.
  always_comb begin
    inc = '0;
    if (!halt) begin
      inc[3] = 1'b1;
      if (retire) begin
        if (op == 6'h00) begin
          inc[1] = 1'b1;
        end else if (op == 6'h02 || op == 6'h03) begin
          inc[0] = 1'b1;
        end else begin
          inc[2] = 1'b1;
        end
      end
      inc[NCH-1:4] = ev;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (inc[c]) begin
        if (&cnt_q[c]) begin
          ovf_d[c] = 1'b1;
`ifdef PERF_SATURATE_EN
          cnt_d[c] = cnt_q[c];
`else
          cnt_d[c] = '0;
`endif
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
    // Clear overrides any increment landing on the same edge.
    if (clr) begin
      ovf_d = '0;
      for (int c = 0; c < NCH; c++) begin
        cnt_d[c] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= '0;
        shad_q[c] <= '0;
      end
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
        // Shadows take the pre-increment, pre-clear live value.
        if (snap) begin
          shad_q[c] <= cnt_q[c];
        end
      end
      ovf_q <= ovf_d;
      if (snap) begin
        snap_valid_q <= 1'b1;
      end
    end
  end

  // Compare-based mux so out-of-range selects read as zero without indexing past the array.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_sel == SEL_W'(c)) begin
        rd_data = shad_q[c];
      end
    end
  end

  assign statJ      = cnt_q[0];
  assign statR      = cnt_q[1];
  assign statI      = cnt_q[2];
  assign statTC     = cnt_q[3];
  assign ovf        = ovf_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic        retire, halt, clr, snap;
  logic [3:0]  ev;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data, statJ, statR, statI, statTC;
  logic [7:0]  ovf;
  logic        snap_valid;

  // Narrow instance for wrap/saturate behaviour.
  logic [3:0]  ev2;
  logic        clr2, snap2;
  logic [3:0]  rd_sel2;
  logic [3:0]  rd_data2, statJ2, statR2, statI2, statTC2;
  logic [7:0]  ovf2;
  logic        snap_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.CNT_W(32), .N_EXT(4), .SEL_W(4)) dut (
    .clk(clk), .reset(rst_n), .op(op), .retire(retire), .halt(halt), .ev(ev),
    .clr(clr), .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data),
    .statJ(statJ), .statR(statR), .statI(statI), .statTC(statTC),
    .ovf(ovf), .snap_valid(snap_valid)
  );

  perf_counter_bank #(.CNT_W(4), .N_EXT(4), .SEL_W(4)) dut4 (
    .clk(clk), .reset(rst_n), .op(6'h00), .retire(1'b0), .halt(1'b0), .ev(ev2),
    .clr(clr2), .snap(snap2), .rd_sel(rd_sel2), .rd_data(rd_data2),
    .statJ(statJ2), .statR(statR2), .statI(statI2), .statTC(statTC2),
    .ovf(ovf2), .snap_valid(snap_valid2)
  );

  typedef struct {
    logic [5:0]  op;
    logic        retire;
    logic        halt;
    logic [3:0]  ev;
    logic        clr;
    logic        snap;
    logic [3:0]  rd_sel;
    logic [31:0] j, r, i, tc, rd;
    logic [7:0]  ovf;
    logic        sv;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [5:0] op_v, input logic ret_v, input logic halt_v,
                              input logic [3:0] ev_v, input logic clr_v, input logic snap_v,
                              input logic [3:0] sel_v, input int j_v, input int r_v,
                              input int i_v, input int tc_v, input int rd_v, input logic sv_v);
    vec_t v;
    v.op = op_v; v.retire = ret_v; v.halt = halt_v; v.ev = ev_v;
    v.clr = clr_v; v.snap = snap_v; v.rd_sel = sel_v;
    v.j = j_v; v.r = r_v; v.i = i_v; v.tc = tc_v; v.rd = rd_v;
    v.ovf = 8'h00; v.sv = sv_v;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            op     ret  hlt  ev     clr  snp  sel    J  R  I  TC  rd  sv
    tbl[0]  = mk(6'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 0, 1, 0, 1,  0, 1'b0);
    tbl[1]  = mk(6'h02, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1, 1, 0, 2,  0, 1'b0);
    tbl[2]  = mk(6'h23, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1, 1, 1, 3,  0, 1'b0);
    tbl[3]  = mk(6'h03, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 2, 1, 1, 4,  0, 1'b0);
    tbl[4]  = mk(6'h2B, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 2, 1, 2, 5,  0, 1'b0);
    tbl[5]  = mk(6'h00, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 2, 1, 2, 6,  0, 1'b0);
    tbl[6]  = mk(6'h00, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 4'd0, 2, 1, 2, 7,  0, 1'b0);
    tbl[7]  = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 2, 1, 2, 8,  0, 1'b0);
    tbl[8]  = mk(6'h00, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 2, 1, 2, 8,  0, 1'b0);
    tbl[9]  = mk(6'h02, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 2, 1, 2, 8,  0, 1'b0);
    tbl[10] = mk(6'h23, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'd3, 2, 1, 2, 8,  8, 1'b1);
    tbl[11] = mk(6'h00, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'd4, 2, 1, 2, 8,  2, 1'b1);
    tbl[12] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5, 2, 1, 2, 9,  1, 1'b1);
    tbl[13] = mk(6'h00, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 0, 0, 0, 0,  2, 1'b1);
    tbl[14] = mk(6'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 1,  0, 1'b1);
    tbl[15] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 2,  0, 1'b1);
    tbl[16] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 3,  0, 1'b1);
    tbl[17] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 4,  0, 1'b1);
    tbl[18] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 5,  0, 1'b1);
    tbl[19] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 6,  0, 1'b1);
    tbl[20] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 0, 1, 0, 7,  0, 1'b1);
    tbl[21] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'd3, 0, 0, 0, 0,  7, 1'b1);
    tbl[22] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd9, 0, 0, 0, 1,  0, 1'b1);
    tbl[23] = mk(6'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd1, 0, 0, 0, 2,  1, 1'b1);

    op = 6'h00; retire = 1'b0; halt = 1'b0; ev = 4'h0; clr = 1'b0; snap = 1'b0; rd_sel = 4'd0;
    ev2 = 4'h0; clr2 = 1'b0; snap2 = 1'b0; rd_sel2 = 4'd0;
    rst_n = 1'b0;
    #2;
    chk("reset_statJ", statJ, 32'd0);
    chk("reset_statTC", statTC, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_ovf", {24'd0, ovf}, 32'd0);
    chk("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 24; k++) begin
      op = tbl[k].op; retire = tbl[k].retire; halt = tbl[k].halt; ev = tbl[k].ev;
      clr = tbl[k].clr; snap = tbl[k].snap; rd_sel = tbl[k].rd_sel;
      tick();
      chk($sformatf("v%0d_statJ", k),  statJ,  tbl[k].j);
      chk($sformatf("v%0d_statR", k),  statR,  tbl[k].r);
      chk($sformatf("v%0d_statI", k),  statI,  tbl[k].i);
      chk($sformatf("v%0d_statTC", k), statTC, tbl[k].tc);
      chk($sformatf("v%0d_rd_data", k), rd_data, tbl[k].rd);
      chk($sformatf("v%0d_ovf", k), {24'd0, ovf}, {24'd0, tbl[k].ovf});
      chk($sformatf("v%0d_snap_valid", k), {31'd0, snap_valid}, {31'd0, tbl[k].sv});
    end
    op = 6'h00; retire = 1'b0; halt = 1'b0; ev = 4'h0; clr = 1'b0; snap = 1'b0; rd_sel = 4'd1;

    // Narrow counter: ev[0] driven 17 times with snapshots around the limit.
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    ev2 = 4'h1;
    for (int k = 0; k < 15; k++) tick();
    ev2 = 4'h0; snap2 = 1'b1;
    tick();
    snap2 = 1'b0; rd_sel2 = 4'd4;
    #1;
    chk("w4_ch4_at15", {28'd0, rd_data2}, 32'd15);
    chk("w4_ovf4_at15", {31'd0, ovf2[4]}, 32'd0);
    ev2 = 4'h1;
    tick();
    ev2 = 4'h0; snap2 = 1'b1;
    tick();
    snap2 = 1'b0;
`ifdef PERF_SATURATE_EN
    chk("w4_ch4_at16", {28'd0, rd_data2}, 32'd15);
`else
    chk("w4_ch4_at16", {28'd0, rd_data2}, 32'd0);
`endif
    chk("w4_ovf4_at16", {31'd0, ovf2[4]}, 32'd1);
    ev2 = 4'h1;
    tick();
    ev2 = 4'h0; snap2 = 1'b1;
    tick();
    snap2 = 1'b0;
`ifdef PERF_SATURATE_EN
    chk("w4_ch4_at17", {28'd0, rd_data2}, 32'd15);
`else
    chk("w4_ch4_at17", {28'd0, rd_data2}, 32'd1);
`endif
    chk("w4_ovf4_at17", {31'd0, ovf2[4]}, 32'd1);
    chk("w4_ovf5_idle", {31'd0, ovf2[5]}, 32'd0);

    // Asynchronous reset between edges, with live counts and a taken snapshot.
    chk("pre_reset_rd_data", rd_data, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_statTC", statTC, 32'd0);
    chk("areset_rd_data", rd_data, 32'd0);
    chk("areset_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("areset_ovf_narrow", {24'd0, ovf2}, 32'd0);
    chk("areset_rd_data_narrow", {28'd0, rd_data2}, 32'd0);
    #1;
    rst_n = 1'b1;
    rd_sel = 4'd9;
    tick();
    chk("post_reset_statTC", statTC, 32'd1);
    chk("rd_sel_out_of_range", rd_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
